// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the RAM-backed FIFO controller
// with a prefetching output queue.
package fifo_pkg;

   localparam int RD_LATENCY     = 3;
   localparam int OUTQ_DEPTH     = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MEM_DEPTH  = 16;

   // count spans RAM words plus every word past the RAM (0..MEM_DEPTH+4)
   function automatic int cnt_width(input int mem_depth);
      return $clog2(mem_depth + OUTQ_DEPTH + 1);
   endfunction

endpackage

// File: rtl/fifo_outq.sv
// fifo_outq: small circular output queue; head word drives the
// consumer side, push and pop may happen in the same cycle.
module fifo_outq
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = OUTQ_DEPTH,
   localparam int PW        = $clog2(DEPTH),
   localparam int LW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [LW-1:0]         o_level
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [LW-1:0]         r_level;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_full;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_pop   = i_pop && (r_level != '0);
   assign w_push  = i_push && (!w_full || w_pop);
   assign o_valid = (r_level != '0);
   assign o_data  = r_mem[r_head];
   assign o_level = r_level;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PW'(1);
         if (w_pop)  r_head <= r_head + PW'(1);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= i_data;
   end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO controller over an external dual-port RAM with a
// fixed read latency, prefetching into a small output queue.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
   localparam int CNT_WIDTH  = cnt_width(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  wr_overflow,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  ram_wena,
   output logic [ADDR_WIDTH-1:0] ram_addra,
   output logic [DATA_WIDTH-1:0] ram_dina,
   output logic                  ram_renb,
   output logic [ADDR_WIDTH-1:0] ram_addrb,
   input  logic [DATA_WIDTH-1:0] ram_doutb,
   input  logic                  ram_dvalb
);

   localparam int LVL_W = ADDR_WIDTH + 1;
   localparam int OQ_LW = $clog2(OUTQ_DEPTH + 1);
   localparam int CR_W  = OQ_LW + 1;
   localparam int FL_W  = $clog2(RD_LATENCY + 1);

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [LVL_W-1:0]      r_level;
   logic [1:0]            r_infl;
   logic [FL_W-1:0]       r_flush;
   logic [OQ_LW-1:0]      w_oq_lvl;
   logic [CR_W-1:0]       w_credit;
   logic                  w_push;
   logic                  w_issue;
   logic                  w_pop;
   logic                  w_ret;

   assign full        = (r_level == LVL_W'(MEM_DEPTH));
   assign w_push      = rst && wr_en && !full;
   assign wr_overflow = rst && wr_en && full;
   assign w_pop       = rd_valid && rd_ready;

   // words already committed past the RAM, after this cycle's pop
   assign w_credit = CR_W'(r_infl) + CR_W'(w_oq_lvl) - CR_W'(w_pop);
   assign w_issue  = rst && (r_level != '0)
                   && (w_credit < CR_W'(OUTQ_DEPTH));
   assign w_ret    = ram_dvalb && (r_flush == '0);

   assign ram_wena  = w_push;
   assign ram_addra = r_wptr;
   assign ram_dina  = wr_data;
   assign ram_renb  = w_issue;
   assign ram_addrb = r_rptr;

   assign count = CNT_WIDTH'(r_level) + CNT_WIDTH'(r_infl)
                + CNT_WIDTH'(w_oq_lvl);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_infl  <= '0;
         r_flush <= FL_W'(RD_LATENCY);
      end else begin
         if (w_push)  r_wptr <= r_wptr + ADDR_WIDTH'(1);
         if (w_issue) r_rptr <= r_rptr + ADDR_WIDTH'(1);
         r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_issue);
         r_infl  <= r_infl + 2'(w_issue) - 2'(w_ret);
         // returns from reads issued before reset land in this window
         if (r_flush != '0) r_flush <= r_flush - FL_W'(1);
      end
   end

   fifo_outq #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OUTQ_DEPTH)
   ) u_outq (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_ret),
      .i_data  (ram_doutb),
      .i_pop   (w_pop),
      .o_valid (rd_valid),
      .o_data  (rd_data),
      .o_level (w_oq_lvl)
   );

endmodule
